// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: layer sequencer for conv_acc_compute.
// Walks output-channel groups and output rows. Fills the activation line ring
// through a single-outstanding row loader, and prefetches the next stride rows
// while the engine works on the current row. It also hands the engine a
// buffer_ready / row_done handshake.
module conv_row_scheduler #(
    parameter int NUM_LINES = 6,
    parameter int ROW_W     = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic [ROW_W-1:0] cfg_img_height,
    input  logic [3:0]       cfg_kernel_size,
    input  logic [3:0]       cfg_stride,
    input  logic [ROW_W-1:0] cfg_oc_groups,
    output logic             ld_req,
    output logic [ROW_W-1:0] ld_row,
    output logic [2:0]       ld_slot,
    input  logic             ld_done,
    output logic             buffer_ready,
    output logic             in_load_phase,
    output logic [2:0]       curr_line_idx,
    input  logic             engine_row_done,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [ROW_W-1:0] ONE = ROW_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        GROUP_START,
        PREFILL,
        READY,
        WAIT_DONE,
        RELEASE,
        ADVANCE,
        FINISH
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       k_q, k_d;            // kernel size K (1 or 3)
    logic [2:0]       s_q, s_d;            // stride S (1 or 2)
    logic [ROW_W-1:0] g_q, g_d;            // number of OC groups
    logic [ROW_W-1:0] rows_q, rows_d;      // output rows per group R
    logic [ROW_W-1:0] group_q, group_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [ROW_W-1:0] next_row_q, next_row_d;  // next input row to load
    logic [2:0]       wptr_q, wptr_d;          // next ring slot to write
    logic [2:0]       idx_q, idx_d;            // curr_line_idx register
    logic [2:0]       loads_left_q, loads_left_d;  // loads still to complete
    logic             ld_req_q, ld_req_d;
    logic [ROW_W-1:0] ld_row_q, ld_row_d;
    logic [2:0]       ld_slot_q, ld_slot_d;
    logic             ilp_q, ilp_d;
    logic             cfg_err_q, cfg_err_d;
    logic             rej_q, rej_d;             // rejected start -> done pulse

    // Ring slot successor, wrapping at the last physical line.
    function automatic logic [2:0] slot_inc(input logic [2:0] slot);
        return (slot == 3'(NUM_LINES - 1)) ? 3'd0 : slot + 3'd1;
    endfunction

    // Configuration checks and the row count R, evaluated on the raw cfg inputs.
    logic             cfg_ok;
    logic [ROW_W-1:0] row_span;
    logic [ROW_W-1:0] rows_calc;
    logic [ROW_W-1:0] last_row;

    assign cfg_ok = ((cfg_kernel_size == 4'd1) || (cfg_kernel_size == 4'd3))
                 && ((cfg_stride == 4'd1) || (cfg_stride == 4'd2))
                 && (ROW_W'(cfg_kernel_size) <= cfg_img_height)
                 && ((5'(cfg_kernel_size) + 5'(cfg_stride)) <= 5'(NUM_LINES))
                 && (cfg_oc_groups != '0);

    assign row_span  = cfg_img_height - ROW_W'(cfg_kernel_size);
    assign rows_calc = ((cfg_stride == 4'd2) ? (row_span >> 1) : row_span) + ONE;
    assign last_row  = rows_q - ONE;

    // Loader handshake events.
    logic ld_fire;      // current request completes this cycle
    logic last_fire;    // the final pending load completes this cycle
    logic loads_clear;  // no load pending after this cycle

    assign ld_fire     = ld_req_q && ld_done;
    assign last_fire   = ld_fire && (loads_left_q == 3'd1);
    assign loads_clear = (loads_left_q == 3'd0) || last_fire;

    // Next-state logic: loader sequencing followed by the layer FSM.
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        s_d          = s_q;
        g_d          = g_q;
        rows_d       = rows_q;
        group_d      = group_q;
        out_row_d    = out_row_q;
        next_row_d   = next_row_q;
        wptr_d       = wptr_q;
        idx_d        = idx_q;
        loads_left_d = loads_left_q;
        ld_req_d     = ld_req_q;
        ld_row_d     = ld_row_q;
        ld_slot_d    = ld_slot_q;
        ilp_d        = ilp_q;
        cfg_err_d    = cfg_err_q;
        rej_d        = 1'b0;

        // Loader: one request at a time. A new request rises the cycle after the previous ld_done.
        if ((state_q == PREFILL) || (state_q == WAIT_DONE)) begin
            if (ld_fire) begin
                ld_req_d     = 1'b0;
                next_row_d   = next_row_q + ONE;
                wptr_d       = slot_inc(wptr_q);
                loads_left_d = loads_left_q - 3'd1;
            end else if (!ld_req_q && (loads_left_q != 3'd0)) begin
                ld_req_d  = 1'b1;
                ld_row_d  = next_row_q;
                ld_slot_d = wptr_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_err_d = !cfg_ok;
                    if (cfg_ok) begin
                        k_d     = cfg_kernel_size[2:0];
                        s_d     = cfg_stride[2:0];
                        g_d     = cfg_oc_groups;
                        rows_d  = rows_calc;
                        group_d = '0;
                        state_d = GROUP_START;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            GROUP_START: begin
                wptr_d       = '0;
                next_row_d   = '0;
                out_row_d    = '0;
                ilp_d        = 1'b1;
                loads_left_d = k_q;
                state_d      = PREFILL;
            end
            PREFILL: begin
                if (last_fire) begin
                    idx_d   = slot_inc(wptr_q);
                    state_d = READY;
                end
            end
            READY: begin
                // Prefetch the rows the next output row needs, unless this is the last row.
                loads_left_d = (out_row_q < last_row) ? s_q : 3'd0;
                state_d      = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (engine_row_done) begin
                    ilp_d = 1'b0;
                    if (loads_clear || (out_row_q == last_row)) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (!engine_row_done) begin
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (out_row_q < last_row) begin
                    out_row_d = out_row_q + ONE;
                    idx_d     = wptr_q;
                    state_d   = READY;
                end else if (group_q < (g_q - ONE)) begin
                    group_d = group_q + ONE;
                    state_d = GROUP_START;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously so a reset aborts the layer at once.
    // NOTE: clocked state uses <= so every register samples pre-edge values regardless of order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            k_q          <= '0;
            s_q          <= '0;
            g_q          <= '0;
            rows_q       <= '0;
            group_q      <= '0;
            out_row_q    <= '0;
            next_row_q   <= '0;
            wptr_q       <= '0;
            idx_q        <= '0;
            loads_left_q <= '0;
            ld_req_q     <= 1'b0;
            ld_row_q     <= '0;
            ld_slot_q    <= '0;
            ilp_q        <= 1'b0;
            cfg_err_q    <= 1'b0;
            rej_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            s_q          <= s_d;
            g_q          <= g_d;
            rows_q       <= rows_d;
            group_q      <= group_d;
            out_row_q    <= out_row_d;
            next_row_q   <= next_row_d;
            wptr_q       <= wptr_d;
            idx_q        <= idx_d;
            loads_left_q <= loads_left_d;
            ld_req_q     <= ld_req_d;
            ld_row_q     <= ld_row_d;
            ld_slot_q    <= ld_slot_d;
            ilp_q        <= ilp_d;
            cfg_err_q    <= cfg_err_d;
            rej_q        <= rej_d;
        end
    end

    assign ld_req        = ld_req_q;
    assign ld_row        = ld_row_q;
    assign ld_slot       = ld_slot_q;
    assign curr_line_idx = idx_q;
    assign in_load_phase = ilp_q;
    assign cfg_err       = cfg_err_q;
    assign buffer_ready  = (state_q == READY) || (state_q == WAIT_DONE);
    assign busy          = (state_q != IDLE) && (state_q != FINISH);
    assign done          = (state_q == FINISH) || rej_q;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Directed bench for conv_row_scheduler. A behavioural loader and engine respond
// to the scheduler. Load order, ring slots, curr_line_idx and in_load_phase per
// row are compared against hand values and a small reference sequence built
// from the layer configuration.
module tb_conv_row_scheduler;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] cfg_img_height = '0;
    logic [3:0]  cfg_kernel_size = '0;
    logic [3:0]  cfg_stride = '0;
    logic [15:0] cfg_oc_groups = '0;
    logic        ld_req;
    logic [15:0] ld_row;
    logic [2:0]  ld_slot;
    logic        ld_done = 1'b0;
    logic        buffer_ready;
    logic        in_load_phase;
    logic [2:0]  curr_line_idx;
    logic        engine_row_done = 1'b0;
    logic        busy;
    logic        done;
    logic        cfg_err;

    conv_row_scheduler #(.NUM_LINES(6), .ROW_W(16)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .start           (start),
        .cfg_img_height  (cfg_img_height),
        .cfg_kernel_size (cfg_kernel_size),
        .cfg_stride      (cfg_stride),
        .cfg_oc_groups   (cfg_oc_groups),
        .ld_req          (ld_req),
        .ld_row          (ld_row),
        .ld_slot         (ld_slot),
        .ld_done         (ld_done),
        .buffer_ready    (buffer_ready),
        .in_load_phase   (in_load_phase),
        .curr_line_idx   (curr_line_idx),
        .engine_row_done (engine_row_done),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Current layer configuration and responder latencies.
    int h, k, s, g;
    int ld_lat  = 1;
    int eng_lat = 1;

    // Observation logs.
    int ld_rows[$];
    int ld_slots[$];
    int row_idx[$];
    int row_ilp[$];
    int loads_total = 0;
    int lines_viol  = 0;
    int stab_viol   = 0;
    int br_viol     = 0;
    int done_cnt    = 0;
    int req_cycles  = 0;

    function automatic int rows_per_group();
        return ((h - k) >> ((s == 2) ? 1 : 0)) + 1;
    endfunction

    // Lines that must already be written when the n-th row of the layer starts.
    function automatic int need_lines(input int n);
        int rr;
        rr = rows_per_group();
        return (n / rr) * (k + (rr - 1) * s) + k + (n % rr) * s;
    endfunction

    // Row loader: acknowledges each request ld_lat cycles after it is first seen.
    initial begin : loader
        int          cnt;
        logic        prev_req;
        logic [15:0] row_hold;
        logic [2:0]  slot_hold;
        cnt = 0;
        prev_req = 1'b0;
        row_hold = '0;
        slot_hold = '0;
        forever begin
            @(negedge aclk);
            ld_done = 1'b0;
            if (ld_req) begin
                if (!prev_req) begin
                    row_hold  = ld_row;
                    slot_hold = ld_slot;
                    cnt       = 0;
                end else if ((ld_row != row_hold) || (ld_slot != slot_hold)) begin
                    stab_viol++;
                end
                if (cnt >= ld_lat) begin
                    ld_done = 1'b1;
                    ld_rows.push_back(int'(ld_row));
                    ld_slots.push_back(int'(ld_slot));
                    loads_total++;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
            prev_req = ld_req;
        end
    end

    // Engine: logs each row start and raises row_done eng_lat cycles later until released.
    initial begin : engine
        int   cnt;
        logic prev_br;
        cnt = 0;
        prev_br = 1'b0;
        forever begin
            @(negedge aclk);
            if (!buffer_ready) begin
                if (prev_br && !engine_row_done && aresetn) br_viol++;
                engine_row_done = 1'b0;
                cnt = 0;
            end else begin
                if (!prev_br) begin
                    if (loads_total < need_lines(row_idx.size())) lines_viol++;
                    row_idx.push_back(int'(curr_line_idx));
                    row_ilp.push_back(int'(in_load_phase));
                    cnt = 0;
                end
                if (!engine_row_done) begin
                    if (cnt >= eng_lat) engine_row_done = 1'b1;
                    else cnt++;
                end
            end
            prev_br = buffer_ready;
        end
    end

    always @(negedge aclk) begin
        if (done) done_cnt++;
        if (ld_req) req_cycles++;
    end

    task automatic clear_logs();
        ld_rows.delete();
        ld_slots.delete();
        row_idx.delete();
        row_ilp.delete();
        loads_total = 0;
        lines_viol  = 0;
        stab_viol   = 0;
        br_viol     = 0;
        done_cnt    = 0;
        req_cycles  = 0;
    endtask

    task automatic pulse_start(input int hh, input int kk, input int ss, input int gg);
        @(negedge aclk);
        cfg_img_height  = 16'(hh);
        cfg_kernel_size = 4'(kk);
        cfg_stride      = 4'(ss);
        cfg_oc_groups   = 16'(gg);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    // Runs one full layer and compares everything against the reference sequence.
    task automatic run_layer(input string name, input int hh, input int kk, input int ss,
                             input int gg, input int ldl, input int el);
        int exp_rows[$];
        int exp_slots[$];
        int exp_idx[$];
        int exp_ilp[$];
        int wp, nr, rr, cyc;
        h = hh; k = kk; s = ss; g = gg;
        ld_lat = ldl; eng_lat = el;
        rr = rows_per_group();
        for (int gi = 0; gi < gg; gi++) begin
            wp = 0;
            nr = 0;
            for (int i = 0; i < kk; i++) begin
                exp_rows.push_back(nr); exp_slots.push_back(wp);
                nr++; wp = (wp + 1) % 6;
            end
            for (int r = 0; r < rr; r++) begin
                exp_idx.push_back(wp);
                exp_ilp.push_back((r == 0) ? 1 : 0);
                if (r < rr - 1) begin
                    for (int i = 0; i < ss; i++) begin
                        exp_rows.push_back(nr); exp_slots.push_back(wp);
                        nr++; wp = (wp + 1) % 6;
                    end
                end
            end
        end
        clear_logs();
        pulse_start(hh, kk, ss, gg);
        check($sformatf("%s.busy_after_start", name), int'(busy), 1);
        cyc = 0;
        while ((done_cnt == 0) && (cyc < 20000)) begin
            @(negedge aclk);
            cyc++;
        end
        check($sformatf("%s.finished_in_time", name), int'(done_cnt > 0), 1);
        repeat (3) @(negedge aclk);
        check($sformatf("%s.done_pulses", name), done_cnt, 1);
        check($sformatf("%s.busy_end", name), int'(busy), 0);
        check($sformatf("%s.cfg_err", name), int'(cfg_err), 0);
        check($sformatf("%s.ld_req_end", name), int'(ld_req), 0);
        check($sformatf("%s.num_loads", name), ld_rows.size(), exp_rows.size());
        for (int i = 0; i < exp_rows.size(); i++) begin
            if (i < ld_rows.size()) begin
                check($sformatf("%s.ld_row[%0d]", name, i), ld_rows[i], exp_rows[i]);
                check($sformatf("%s.ld_slot[%0d]", name, i), ld_slots[i], exp_slots[i]);
            end
        end
        check($sformatf("%s.num_rows", name), row_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size(); i++) begin
            if (i < row_idx.size()) begin
                check($sformatf("%s.line_idx[%0d]", name, i), row_idx[i], exp_idx[i]);
                check($sformatf("%s.in_load_phase[%0d]", name, i), row_ilp[i], exp_ilp[i]);
            end
        end
        check($sformatf("%s.ready_before_lines", name), lines_viol, 0);
        check($sformatf("%s.ld_unstable", name), stab_viol, 0);
        check($sformatf("%s.ready_dropped_early", name), br_viol, 0);
    endtask

    // A rejected configuration: done one cycle after start, cfg_err set, no loads.
    task automatic bad_cfg(input string name, input int hh, input int kk, input int ss,
                           input int gg);
        clear_logs();
        pulse_start(hh, kk, ss, gg);
        check($sformatf("%s.done", name), int'(done), 1);
        check($sformatf("%s.cfg_err", name), int'(cfg_err), 1);
        check($sformatf("%s.busy", name), int'(busy), 0);
        @(negedge aclk);
        check($sformatf("%s.done_low", name), int'(done), 0);
        check($sformatf("%s.cfg_err_sticky", name), int'(cfg_err), 1);
        repeat (5) @(negedge aclk);
        check($sformatf("%s.no_ld_req", name), req_cycles, 0);
        check($sformatf("%s.done_count", name), done_cnt, 1);
    endtask

    task automatic check_all_low(input string name);
        check($sformatf("%s.ld_req", name), int'(ld_req), 0);
        check($sformatf("%s.ld_row", name), int'(ld_row), 0);
        check($sformatf("%s.ld_slot", name), int'(ld_slot), 0);
        check($sformatf("%s.buffer_ready", name), int'(buffer_ready), 0);
        check($sformatf("%s.in_load_phase", name), int'(in_load_phase), 0);
        check($sformatf("%s.curr_line_idx", name), int'(curr_line_idx), 0);
        check($sformatf("%s.busy", name), int'(busy), 0);
        check($sformatf("%s.done", name), int'(done), 0);
        check($sformatf("%s.cfg_err", name), int'(cfg_err), 0);
    endtask

    initial begin : main
        int hand_idx1[3];
        int hand_idx2[3];
        int hand_slot2[4];
        int cyc;
        hand_idx1  = '{3, 4, 5};
        hand_idx2  = '{3, 5, 1};
        hand_slot2 = '{3, 4, 5, 0};

        repeat (3) @(negedge aclk);
        check_all_low("reset");
        aresetn = 1'b1;

        // H=5,K=3,S=1: prefill rows 0..2 into slots 0..2, curr_line_idx 3,4,5.
        run_layer("h5k3s1", 5, 3, 1, 1, 2, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < row_idx.size()) check($sformatf("h5k3s1.hand_idx[%0d]", i), row_idx[i], hand_idx1[i]);
        end

        // H=7,K=3,S=2: prefetch pairs into slots (3,4),(5,0); curr_line_idx 3,5,1.
        run_layer("h7k3s2", 7, 3, 2, 1, 1, 2);
        for (int i = 0; i < 3; i++) begin
            if (i < row_idx.size()) check($sformatf("h7k3s2.hand_idx[%0d]", i), row_idx[i], hand_idx2[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (i + 3 < ld_slots.size()) check($sformatf("h7k3s2.hand_slot[%0d]", i + 3), ld_slots[i + 3], hand_slot2[i]);
        end

        // H=4,K=1,S=1,G=2: 4 rows per group, bias reload flagged once per group.
        run_layer("h4k1g2", 4, 1, 1, 2, 1, 1);
        check("h4k1g2.total_rows", row_idx.size(), 8);

        // Slow loader vs fast engine: the row exit waits for the prefetch.
        run_layer("slow_ld", 5, 3, 1, 1, 50, 10);

        // Rejected configurations.
        bad_cfg("bad_h2k3", 2, 3, 1, 1);
        bad_cfg("bad_s4", 8, 3, 4, 1);
        bad_cfg("bad_g0", 8, 3, 1, 0);

        // Reset while a prefetch request is pending in WAIT_DONE.
        clear_logs();
        h = 7; k = 3; s = 2; g = 1;
        ld_lat = 20; eng_lat = 2;
        pulse_start(7, 3, 2, 1);
        cyc = 0;
        while (!(buffer_ready && ld_req) && (cyc < 2000)) begin
            @(negedge aclk);
            cyc++;
        end
        check("rst_mid.reached_wait_done", int'(buffer_ready && ld_req), 1);
        aresetn = 1'b0;
        #1;
        check_all_low("rst_mid_now");
        @(negedge aclk);
        check_all_low("rst_mid_next");
        aresetn = 1'b1;
        run_layer("post_rst", 7, 3, 2, 1, 1, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
